// File: rtl/boot_loader_pkg.sv
// Shared definitions for the UART boot loader.
// Holds the loader and receiver state encodings, the sync byte value and the
// default timing parameters used by boot_loader and uart_rx.
package boot_loader_pkg;

  localparam logic [7:0] SYNC_BYTE            = 8'hA5;
  localparam int         DEFAULT_CLKS_PER_BIT = 868;
  localparam int         DEFAULT_TIMEOUT_CLKS = 10_000_000;
  localparam int         DEFAULT_MAX_WORDS    = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } load_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/boot_loader_if.sv
// Instruction-memory write port driven by the boot loader.
//   we    : one-cycle write strobe
//   addr  : word-aligned byte address of the write
//   wdata : instruction word to write
// master = loader side (drives), slave = memory side (receives).
interface boot_loader_if;

  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  modport master (output we, addr, wdata);
  modport slave  (input  we, addr, wdata);

endinterface

// File: rtl/boot_loader_uart_rx.sv
// UART 8N1 receiver for the boot loader.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   rxd_i           : raw serial input, idles high
//   byte_valid_o    : one-cycle pulse when a well-framed byte arrives
//   byte_data_o     : received byte, held until the next good byte
//   frame_err_o     : one-cycle pulse when the stop bit is sampled low
module uart_rx
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state_q;
  logic          sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          frameErr_q;

  // Synchronise the serial line, then walk through start, data and stop bits.
  // The start bit is re-checked half a bit after the falling edge so short
  // glitches fall back to idle; every later sample lands mid-bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      sync1_q    <= rxd_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (sync2_q) begin
              state_q <= RX_IDLE;
            end else begin
              state_q  <= RX_DATA;
              bitIdx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            if (bitIdx_q == 3'd7) state_q <= RX_STOP;
            else                  bitIdx_q <= bitIdx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              valid_q <= 1'b1;
              data_q  <= shift_q;
            end else begin
              frameErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = frameErr_q;

endmodule

// File: rtl/boot_loader.sv
// UART boot loader: receives A5 / LEN_LO / LEN_HI / data words / XOR checksum
// and writes the image into instruction memory, holding the cpu in reset until
// a complete image with a matching checksum has been accepted.
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   uart_rxd_i   : UART 8N1 serial input
//   imem         : instruction-memory write port (master side)
//   cpu_rst_o    : active-high cpu reset, low only once the image is accepted
//   done_o       : image loaded and checksum matched
//   error_o      : framing, length, checksum or timeout failure
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int MAX_WORDS    = DEFAULT_MAX_WORDS,
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uart_rxd_i,
  boot_loader_if.master imem,
  output logic          cpu_rst_o,
  output logic          done_o,
  output logic          error_o
);

  localparam int            TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]   MAX_W   = 17'(MAX_WORDS);

  logic       byteValid;
  logic [7:0] byteData;
  logic       frameErr;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rxd_i       (uart_rxd_i),
    .byte_valid_o(byteValid),
    .byte_data_o (byteData),
    .frame_err_o (frameErr)
  );

  load_state_e   state_q, state_d;
  logic [7:0]    lenLo_q;
  logic [15:0]   len_q;
  logic [15:0]   wordIdx_q;
  logic [1:0]    lane_q;
  logic [7:0]    csum_q;
  logic [23:0]   wordBuf_q;
  logic [TW-1:0] idleCnt_q;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic          cpuRst_q, done_q, error_q;

  logic [15:0] lenNew_d;
  logic [31:0] wordAsm_d;
  logic        inXfer, timeoutHit, lastWord;

  assign lenNew_d   = {byteData, lenLo_q};
  assign wordAsm_d  = {byteData, wordBuf_q};
  assign inXfer     = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
  assign timeoutHit = inXfer && !byteValid && (idleCnt_q == TO_LAST);
  assign lastWord   = (wordIdx_q == len_q - 16'd1);

  // Next-state decision. Frame errors and the idle timeout only matter while
  // a transfer is open, so they override whatever the byte would have done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (byteValid && byteData == SYNC_BYTE) state_d = ST_LEN_LO;
      ST_LEN_LO: if (byteValid) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (byteValid) begin
          if ({1'b0, lenNew_d} > MAX_W) state_d = ST_ERR;
          else if (lenNew_d == 16'd0)   state_d = ST_CSUM;
          else                          state_d = ST_DATA;
        end
      end
      ST_DATA:   if (byteValid && lane_q == 2'd3 && lastWord) state_d = ST_CSUM;
      ST_CSUM:   if (byteValid) state_d = (byteData == csum_q) ? ST_DONE : ST_ERR;
      ST_DONE:   state_d = ST_DONE;
      ST_ERR:    if (byteValid && byteData == SYNC_BYTE) state_d = ST_LEN_LO;
      default:   state_d = ST_IDLE;
    endcase
    if (inXfer && (frameErr || timeoutHit)) state_d = ST_ERR;
  end

  // Loader registers. Status outputs are decoded from the next state so they
  // change together with the state register and never glitch. Bytes 0..2 of
  // a word shift into wordBuf_q from the top, so the fourth byte completes a
  // little-endian word and the write strobe fires on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lenLo_q   <= '0;
      len_q     <= '0;
      wordIdx_q <= '0;
      lane_q    <= '0;
      csum_q    <= '0;
      wordBuf_q <= '0;
      idleCnt_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpuRst_q  <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= 1'b0;
      cpuRst_q  <= (state_d != ST_DONE);
      done_q    <= (state_d == ST_DONE);
      error_q   <= (state_d == ST_ERR);
      idleCnt_q <= (inXfer && !byteValid) ? idleCnt_q + 1'b1 : '0;
      if (byteValid) begin
        case (state_q)
          ST_IDLE, ST_ERR: begin
            if (byteData == SYNC_BYTE) begin
              wordIdx_q <= '0;
              lane_q    <= '0;
              csum_q    <= '0;
            end
          end
          ST_LEN_LO: lenLo_q <= byteData;
          ST_LEN_HI: len_q   <= lenNew_d;
          ST_DATA: begin
            csum_q <= csum_q ^ byteData;
            lane_q <= lane_q + 1'b1;
            if (lane_q == 2'd3) begin
              we_q      <= 1'b1;
              addr_q    <= {14'd0, wordIdx_q, 2'b00};
              wdata_q   <= wordAsm_d;
              wordIdx_q <= wordIdx_q + 1'b1;
            end else begin
              wordBuf_q <= {byteData, wordBuf_q[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem.we    = we_q;
  assign imem.addr  = addr_q;
  assign imem.wdata = wdata_q;
  assign cpu_rst_o  = cpuRst_q;
  assign done_o     = done_q;
  assign error_o    = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed protocol cases plus random
// images, all judged against a byte-stream parser model kept in this file.
module tb_boot_loader;
  import boot_loader_pkg::*;

  localparam int CPB  = 4;
  localparam int TO   = 200;
  localparam int WAIT = TO + 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic cpuRst, done, err;

  boot_loader_if imemBus ();

  boot_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(256), .TIMEOUT_CLKS(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rxd_i(rxd),
    .imem      (imemBus),
    .cpu_rst_o (cpuRst),
    .done_o    (done),
    .error_o   (err)
  );

  always #5 clk = ~clk;

  logic [31:0] gotAddr[$], gotData[$], expAddr[$], expData[$];
  logic        expDone, expErr;
  logic [7:0]  stream[$];
  int          checks = 0;
  int          errors = 0;

  // Record every memory write seen mid-cycle.
  always @(negedge clk) begin
    if (rst_n && imemBus.we) begin
      gotAddr.push_back(imemBus.addr);
      gotData.push_back(imemBus.wdata);
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stopBit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input int from);
    for (int i = from; i < stream.size(); i++) sendByte(stream[i], 1'b1);
    repeat (WAIT) @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gotAddr.delete();
    gotData.delete();
    repeat (2) @(negedge clk);
  endtask

  // Parse the whole byte stream from reset: hunt for A5, read the length,
  // collect complete words, then compare the checksum. A stream that stops
  // mid-transfer counts as an error because the bench always idles past the
  // timeout after sending.
  task automatic runModel();
    int          i;
    int          n;
    bit          trunc;
    logic [7:0]  cs;
    logic [31:0] w;
    i = 0;
    expAddr.delete();
    expData.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    while (i < stream.size()) begin
      if (expDone) break;
      if (stream[i] != SYNC_BYTE) begin
        i++;
        continue;
      end
      i++;
      expErr = 1'b0;
      if (i + 2 > stream.size()) begin
        expErr = 1'b1;
        break;
      end
      n = int'(stream[i]) + 256 * int'(stream[i+1]);
      i += 2;
      if (n > 256) begin
        expErr = 1'b1;
        continue;
      end
      cs    = 8'h00;
      trunc = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (i + 4 > stream.size()) begin
          trunc = 1'b1;
          break;
        end
        w  = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
        cs = cs ^ stream[i] ^ stream[i+1] ^ stream[i+2] ^ stream[i+3];
        expAddr.push_back(32'(k * 4));
        expData.push_back(w);
        i += 4;
      end
      if (trunc || i >= stream.size()) begin
        expErr = 1'b1;
        break;
      end
      if (stream[i] == cs) expDone = 1'b1;
      else                 expErr  = 1'b1;
      i++;
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal($sformatf("%s_nwrites", tag), 32'(gotAddr.size()), 32'(expAddr.size()));
    for (int i = 0; i < expAddr.size() && i < gotAddr.size(); i++) begin
      checkVal($sformatf("%s_addr%0d", tag, i), gotAddr[i], expAddr[i]);
      checkVal($sformatf("%s_data%0d", tag, i), gotData[i], expData[i]);
    end
    checkVal({tag, "_done"},    32'(done),   32'(expDone));
    checkVal({tag, "_error"},   32'(err),    32'(expErr));
    checkVal({tag, "_cpu_rst"}, 32'(cpuRst), 32'(!expDone));
  endtask

  initial begin
    int          n;
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;

    // Reset values
    repeat (3) @(negedge clk);
    checkVal("rst_cpu_rst", 32'(cpuRst), 32'd1);
    checkVal("rst_done",    32'(done),   32'd0);
    checkVal("rst_error",   32'(err),    32'd0);
    checkVal("rst_we",      32'(imemBus.we), 32'd0);
    checkVal("rst_addr",    imemBus.addr,  32'd0);
    checkVal("rst_wdata",   imemBus.wdata, 32'd0);
    doReset();

    // Good load; the checksum of 13 00 00 00 B3 00 50 00 is 0x13^0xB3^0x50 = 0xF0
    stream = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
    applyStimulus(0);
    runModel();
    checkOutput("good");
    checkVal("good_w0_const", gotData.size() > 0 ? gotData[0] : 32'hDEAD, 32'h0000_0013);
    checkVal("good_w1_const", gotData.size() > 1 ? gotData[1] : 32'hDEAD, 32'h0050_00B3);

    // Bad checksum, then an empty image recovers
    doReset();
    stream = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hB3, 8'h00, 8'h50, 8'h00, 8'h84};
    applyStimulus(0);
    runModel();
    checkOutput("badcs");
    stream = {stream, 8'hA5, 8'h00, 8'h00, 8'h00};
    applyStimulus(12);
    runModel();
    checkOutput("recover");

    // Low stop bit inside DATA
    doReset();
    sendByte(8'hA5, 1'b1);
    sendByte(8'h01, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h13, 1'b1);
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b1);
    sendByte(8'h00, 1'b1);
    repeat (WAIT) @(negedge clk);
    expAddr.delete();
    expData.delete();
    expDone = 1'b0;
    expErr  = 1'b1;
    checkOutput("frame");

    // Length above the limit
    doReset();
    stream = {8'hA5, 8'h01, 8'h01};
    applyStimulus(0);
    runModel();
    checkOutput("len257");

    // Idle timeout mid-word
    doReset();
    stream = {8'hA5, 8'h01, 8'h00, 8'h13};
    applyStimulus(0);
    runModel();
    checkOutput("timeout");

    // Short glitch, then noise bytes in idle, then a good image
    doReset();
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    stream = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    applyStimulus(0);
    runModel();
    checkOutput("noise");

    // Reset in the middle of a fresh transfer that follows a failed one
    doReset();
    stream = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'hB3, 8'h00, 8'h50, 8'h00, 8'h84};
    applyStimulus(0);
    sendByte(8'hA5, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h00, 1'b1);
    sendByte(8'h13, 1'b1);
    sendByte(8'h00, 1'b1);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_cpu_rst", 32'(cpuRst), 32'd1);
    checkVal("midrst_done",    32'(done),   32'd0);
    checkVal("midrst_error",   32'(err),    32'd0);
    checkVal("midrst_we",      32'(imemBus.we), 32'd0);
    checkVal("midrst_addr",    imemBus.addr,  32'd0);
    checkVal("midrst_wdata",   imemBus.wdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    gotAddr.delete();
    gotData.delete();
    stream = {8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'hF0};
    applyStimulus(0);
    runModel();
    checkOutput("afterrst");

    // Random images, some with a corrupted checksum, preceded by noise
    for (int r = 0; r < 6; r++) begin
      doReset();
      stream.delete();
      b = 8'($urandom);
      if (b == SYNC_BYTE) b = 8'h00;
      stream.push_back(b);
      n = int'($urandom_range(1, 4));
      stream = {stream, SYNC_BYTE, 8'(n), 8'h00};
      cs = 8'h00;
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        for (int j = 0; j < 4; j++) begin
          stream.push_back(w[8*j +: 8]);
          cs = cs ^ w[8*j +: 8];
        end
      end
      if (r % 3 == 2) cs = cs ^ 8'h01;
      stream.push_back(cs);
      applyStimulus(0);
      runModel();
      checkOutput($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
